// File: rtl/misr_signature_checker.sv
// BIST response compactor: folds PATTERN_COUNT LFSR words into a MISR and checks it against GOLDEN.
// Latency: 1 cycle per accepted word; done/pass follow the final accept by 1 cycle. No backpressure (patValid only).
// Optional LFSR_SYNC_CTRL_EN: emit a one-cycle lfsrSyncInit pulse after each accepted start.
module misr_signature_checker #(
  parameter int              WIDTH         = 8,
  parameter int              PATTERN_COUNT = 16,
  parameter logic [WIDTH-1:0] SEED         = 8'h00,
  parameter logic [WIDTH-1:0] POLY         = 8'h1D,
  parameter logic [WIDTH-1:0] GOLDEN       = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] patIn,
  input  logic             patValid,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             lfsrSyncInit
);

  localparam int CW = $clog2(PATTERN_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(PATTERN_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sig, sig_next, misr_step;
  logic [CW-1:0]    count, count_next;

  assign misr_step = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ patIn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sig   <= SEED;
      count <= '0;
    end else begin
      state <= state_next;
      sig   <= sig_next;
      count <= count_next;
    end
  end

  // Start wins over patValid outside RUN: the coincident word is dropped.
  always_comb begin
    state_next = state;
    sig_next   = sig;
    count_next = count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          sig_next   = SEED;
          count_next = '0;
        end
      end
      RUN: begin
        if (patValid) begin
          sig_next   = misr_step;
          count_next = count + CW'(1);
          if (count == LAST) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign signature = sig;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (sig == GOLDEN);

`ifdef LFSR_SYNC_CTRL_EN
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 1'b0;
    else        sync_q <= (state != RUN) && start;
  end

  assign lfsrSyncInit = sync_q;
`else
  assign lfsrSyncInit = 1'b0;
`endif

endmodule
